vx_fifo_reader: RTL and testbench

Pop-side companion to the team's FIFO queue. It drains a FIFO's head/empty/pop port into a registered valid/ready stream with full throughput. A two-entry skid stage removes every combinational path from `out_ready` to `fifo_pop`. It also provides a flush-and-discard mode and saturating transfer/drop counters for perf reporting.

---
 rtl/vx_fifo_reader_pkg.sv | 5 +
 rtl/vx_fifo_reader_skid_buffer2.sv | 44 ++++
 rtl/vx_fifo_reader.sv | 69 ++++++
 tb/tb_vx_fifo_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vx_fifo_reader_pkg.sv
// vx_fifo_reader_pkg: shared FSM state type and counter defaults for the FIFO reader
package vx_fifo_reader_pkg;
  typedef enum logic {FR_RUN, FR_FLUSH} fr_state_e;
  localparam int FR_DEF_CNTW = 16;
endpackage

// File: rtl/vx_fifo_reader_skid_buffer2.sv
// vx_skid_buffer2: two-register main/skid stage with synchronous clear and occupancy
module vx_skid_buffer2 #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic             skid_valid,
  output logic [1:0]       occupancy
);
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, main_load;
  logic [DATAW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  // Main reloads when empty or draining; skid only ever fills behind a stalled main.
  always_comb begin
    main_load    = !main_valid_q || out_ready;
    main_valid_d = clear ? 1'b0 : main_load ? (skid_valid_q || in_valid) : main_valid_q;
    main_data_d  = (!clear && main_load && (skid_valid_q || in_valid))
                   ? (skid_valid_q ? skid_data_q : in_data) : main_data_q;
    skid_valid_d = clear ? 1'b0 : main_load ? 1'b0 : (skid_valid_q || in_valid);
    skid_data_d  = (!clear && !main_load && in_valid) ? in_data : skid_data_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
  assign out_valid  = main_valid_q;
  assign out_data   = main_data_q;
  assign skid_valid = skid_valid_q;
  assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
endmodule

// File: rtl/vx_fifo_reader.sv
// vx_fifo_reader: drains a FIFO head/pop port into a registered valid/ready stream,
// with flush-and-discard and saturating transfer/drop counters.
module vx_fifo_reader
  import vx_fifo_reader_pkg::*;
#(
  parameter int DATAW = 1,
  parameter int CNTW  = FR_DEF_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [DATAW-1:0] fifo_data,
  output logic             fifo_pop,
  input  logic             flush,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             flush_busy,
  output logic [CNTW-1:0]  xfer_count,
  output logic [CNTW-1:0]  drop_count
);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  fr_state_e       state_q, state_d;
  logic            run, hs, skid_valid;
  logic [1:0]      occ, drop_add;
  logic [CNTW-1:0] xfer_q, xfer_d, drop_q, drop_d;
  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [1:0] b);
    logic [CNTW:0] s;
    s = {1'b0, a} + {{(CNTW-1){1'b0}}, b};
    return (s > {1'b0, CNT_MAX}) ? CNT_MAX : s[CNTW-1:0];
  endfunction
  assign run = (state_q == FR_RUN);
  assign hs  = out_valid && out_ready;
  // Pop never looks at out_ready: the skid register absorbs the one-cycle lag.
  assign fifo_pop = reset && !fifo_empty && (run ? (!skid_valid && !flush) : 1'b1);
  always_comb begin
    state_d  = run ? (flush ? FR_FLUSH : FR_RUN) : ((fifo_empty && !flush) ? FR_RUN : FR_FLUSH);
    drop_add = run ? (flush ? occ - {1'b0, hs} : 2'd0) : {1'b0, fifo_pop};
    xfer_d   = sat_add(xfer_q, {1'b0, hs});
    drop_d   = sat_add(drop_q, drop_add);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FR_RUN;
      xfer_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      drop_q  <= drop_d;
    end
  end
  vx_skid_buffer2 #(.DATAW(DATAW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush || !run),
    .in_valid   (fifo_pop && run),
    .in_data    (fifo_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .skid_valid (skid_valid),
    .occupancy  (occ)
  );
  assign flush_busy = !run;
  assign xfer_count = xfer_q;
  assign drop_count = drop_q;
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(fifo_pop && fifo_empty));
endmodule

// File: tb/tb_vx_fifo_reader.sv
// tb_vx_fifo_reader: directed and random checks of vx_fifo_reader against a queue-level model
module tb_vx_fifo_reader;
  logic       clk = 0, reset = 0, fifo_empty = 1, flush = 0, out_ready = 0;
  logic [7:0] fifo_data = '0;
  logic       fifo_pop, out_valid, flush_busy, pop2, ov2, fb2;
  logic [7:0] out_data, od2;
  logic [15:0] xfer_count, drop_count;
  logic [1:0] xc2, dc2;
  byte unsigned fq[$], mb[$], got[$];
  int hc[$];
  bit mf;
  int xc, dc, nvec, nerr, cyc, pops;
  vx_fifo_reader #(.DATAW(8), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush_busy(flush_busy), .xfer_count(xfer_count), .drop_count(drop_count));
  vx_fifo_reader #(.DATAW(8), .CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(pop2),
    .flush(flush), .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
    .flush_busy(fb2), .xfer_count(xc2), .drop_count(dc2));
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end
  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic longint sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction
  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask
  task automatic push(input byte unsigned v);
    fq.push_back(v);
    drive_fifo();
  endtask
  task automatic step(input bit rdy, input bit fl);
    bit mp;
    out_ready = rdy;
    flush = fl;
    drive_fifo();
    @(negedge clk);
    mp = (fq.size() > 0) && (mf || (mb.size() < 2 && !fl));
    chk("pop", fifo_pop, mp);
    chk("pop_cntw2", pop2, mp);
    chk("out_valid", out_valid, mb.size() > 0);
    if (mb.size() > 0) chk("out_data", out_data, mb[0]);
    chk("flush_busy", flush_busy, mf);
    chk("xfer_count", xfer_count, sat(xc, 16));
    chk("drop_count", drop_count, sat(dc, 16));
    chk("xfer_count_cntw2", xc2, sat(xc, 2));
    chk("drop_count_cntw2", dc2, sat(dc, 2));
    if (fifo_pop) pops++;
    if (out_valid && rdy) begin
      got.push_back(out_data);
      hc.push_back(cyc);
    end
    if (mb.size() > 0 && rdy) begin
      xc++;
      void'(mb.pop_front());
    end
    if (!mf) begin
      if (fl) begin
        dc += mb.size();
        mb.delete();
        mf = 1;
      end else if (mp) mb.push_back(fq[0]);
    end else begin
      if (mp) dc++;
      if (fq.size() == 0 && !fl) mf = 0;
    end
    if (mp) void'(fq.pop_front());
    cyc++;
    @(posedge clk);
    #1;
    drive_fifo();
  endtask
  initial begin
    int c0, p2, d0, nb, nv;
    push(8'hAA);
    #1;
    chk("rst_pop", fifo_pop, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_drop", drop_count, 0);
    fq.delete();
    drive_fifo();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    // stream 1..8
    got.delete(); hc.delete();
    for (int i = 1; i <= 8; i++) push(8'(i));
    c0 = cyc;
    repeat (12) step(1, 0);
    chk("stream_len", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      chk("stream_word", got[i], i + 1);
      chk("stream_cycle", hc[i], c0 + 1 + i);
    end
    chk("stream_xfer", xfer_count, 8);
    chk("stream_xfer_cntw2", xc2, 3);
    // back-pressure
    got.delete(); hc.delete(); pops = 0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    repeat (2) step(0, 0);
    p2 = pops;
    repeat (3) step(0, 0);
    chk("bp_pops", pops, 2);
    chk("bp_pops_after2", p2, 2);
    chk("bp_hold", out_data, 1);
    c0 = cyc;
    repeat (6) step(1, 0);
    chk("bp_len", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("bp_word", got[i], i + 1);
      chk("bp_cycle", hc[i], c0 + i);
    end
    // flush with main+skid valid and three words queued
    for (int i = 1; i <= 5; i++) push(8'(8'h20 + i));
    repeat (2) step(0, 0);
    d0 = drop_count;
    step(0, 1);
    nb = 0; nv = 0;
    repeat (8) begin
      if (flush_busy) nb++;
      if (flush_busy && out_valid) nv++;
      step(0, 0);
    end
    chk("flush_busy_cycles", nb, 4);
    chk("flush_valid_low", nv, 0);
    chk("flush_drop", drop_count - d0, 5);
    got.delete(); hc.delete();
    push(8'h31); push(8'h32);
    repeat (4) step(1, 0);
    chk("flush_resume_len", got.size(), 2);
    if (got.size() == 2) begin
      chk("flush_resume_w0", got[0], 8'h31);
      chk("flush_resume_w1", got[1], 8'h32);
    end
    // random stress
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0 && fq.size() < 8) push(8'($urandom));
      step(1'($urandom_range(1)), $urandom_range(39) == 0);
    end
    repeat (4) step(0, 1);
    repeat (20) step(1, 0);
    // reset mid-flush
    for (int i = 1; i <= 4; i++) push(8'(8'h40 + i));
    repeat (2) step(0, 0);
    step(0, 1);
    step(0, 0);
    #1 reset = 0;
    #1;
    mb.delete(); mf = 0; xc = 0; dc = 0;
    chk("mid_rst_pop", fifo_pop, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", flush_busy, 0);
    chk("mid_rst_xfer", xfer_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_drop_cntw2", dc2, 0);
    @(posedge clk);
    #1 reset = 1;
    got.delete(); hc.delete();
    repeat (4) step(1, 0);
    chk("post_rst_len", got.size(), 1);
    if (got.size() == 1) chk("post_rst_word", got[0], 8'h44);
    chk("post_rst_xfer", xfer_count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
